// File: rtl/menu_ctrl.sv
// Front-panel menu controller: edge-detected, auto-repeating button events drive a
// browse/edit/apply FSM so the committed options word only ever changes atomically.
module menu_ctrl #(
  parameter int REPEAT_DLY = 50_000_000,
  parameter int REPEAT_PER = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnS,
  output logic [7:0] options,
  output logic [1:0] sel,
  output logic [2:0] cursor,
  output logic       editing,
  output logic       commit
);

  localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  typedef enum logic [1:0] {BROWSE, EDIT, APPLY} state_t;

  // Button vector index: 0=L 1=R 2=U 3=D 4=S
  logic [4:0]    btn;
  logic [4:0]    b_q, b_d, b_qq_q, b_qq_d;
  logic [4:0]    ev_q, ev_d, press;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [1:0]    rpt_q, rpt_d, rep_ev;
  state_t        state_q, state_d;
  logic [7:0]    options_q, options_d, shadow_q, shadow_d;
  logic [1:0]    sel_q, sel_d;
  logic [2:0]    cursor_q, cursor_d;
  logic          editing_q, editing_d, commit_q, commit_d;
  logic          ev_l, ev_r, ev_u, ev_d_btn, ev_s;

  assign btn = {btnS, btnD, btnU, btnR, btnL};

  always_comb begin
    b_d    = btn;
    b_qq_d = b_q;
    press  = b_q & ~b_qq_q;
    rep_ev = 2'b00;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      rpt_d[i] = 1'b0;
      // rpt_q marks that the initial delay has elapsed; the counter then restarts per period
      if (b_q[i]) begin
        if ((!rpt_q[i] && cnt_q[i] == CW'(REPEAT_DLY)) ||
            (rpt_q[i] && cnt_q[i] == CW'(REPEAT_PER))) begin
          rep_ev[i] = 1'b1;
          cnt_d[i]  = CW'(1);
          rpt_d[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
          rpt_d[i] = rpt_q[i];
        end
      end
    end
    ev_d = press | {3'b000, rep_ev};
  end

  assign ev_l     = ev_q[0];
  assign ev_r     = ev_q[1];
  assign ev_u     = ev_q[2];
  assign ev_d_btn = ev_q[3];
  assign ev_s     = ev_q[4];

  always_comb begin
    state_d   = state_q;
    options_d = options_q;
    shadow_d  = shadow_q;
    sel_d     = sel_q;
    cursor_d  = cursor_q;
    commit_d  = 1'b0;
    case (state_q)
      APPLY: begin
        options_d = shadow_q;
        commit_d  = 1'b1;
        state_d   = BROWSE;
      end
      default: begin
        if (ev_s) begin
          if (state_q == BROWSE) begin
            shadow_d = options_q;
            state_d  = EDIT;
          end else begin
            state_d = APPLY;
          end
        end else if (ev_l && ev_r) begin
          if (state_q == EDIT) state_d = BROWSE;
        end else begin
          if (ev_l) cursor_d = cursor_q - 3'd1;
          if (ev_r) cursor_d = cursor_q + 3'd1;
          // U/D act on the cursor position from before any move this cycle
          if (ev_u != ev_d_btn) begin
            if (state_q == BROWSE) sel_d = ev_u ? sel_q + 2'd1 : sel_q - 2'd1;
            else                   shadow_d[cursor_q] = ev_u;
          end
        end
      end
    endcase
    editing_d = (state_d == EDIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q       <= '0;
      b_qq_q    <= '0;
      ev_q      <= '0;
      rpt_q     <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      state_q   <= BROWSE;
      options_q <= '0;
      shadow_q  <= '0;
      sel_q     <= '0;
      cursor_q  <= '0;
      editing_q <= 1'b0;
      commit_q  <= 1'b0;
    end else begin
      b_q       <= b_d;
      b_qq_q    <= b_qq_d;
      ev_q      <= ev_d;
      rpt_q     <= rpt_d;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
      state_q   <= state_d;
      options_q <= options_d;
      shadow_q  <= shadow_d;
      sel_q     <= sel_d;
      cursor_q  <= cursor_d;
      editing_q <= editing_d;
      commit_q  <= commit_d;
    end
  end

  assign options = options_q;
  assign sel     = sel_q;
  assign cursor  = cursor_q;
  assign editing = editing_q;
  assign commit  = commit_q;

endmodule

// File: tb/tb_menu_ctrl.sv
// Self-checking bench for menu_ctrl: a hold-duration based reference model is compared
// against the DUT every cycle, plus directed literal checks from the menu scenarios.
module tb_menu_ctrl;
  localparam int DLY = 20;
  localparam int PER = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] btns = 5'b0;   // 0=L 1=R 2=U 3=D 4=S
  logic [7:0] options;
  logic [1:0] sel;
  logic [2:0] cursor;
  logic       editing, commit;

  menu_ctrl #(.REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut (
    .clk(clk), .rst_n(rst_n),
    .btnL(btns[0]), .btnR(btns[1]), .btnU(btns[2]), .btnD(btns[3]), .btnS(btns[4]),
    .options(options), .sel(sel), .cursor(cursor), .editing(editing), .commit(commit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int commits_seen = 0;
  bit chk_en = 0;

  // Reference model: mode 0=browse 1=edit 2=apply
  int         m_mode, m_cur, m_sel;
  logic [7:0] m_opt, m_shadow;
  bit         m_commit;
  int         held [5];
  logic [4:0] evp [2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cur = 0; m_sel = 0; m_opt = 8'h00; m_shadow = 8'h00; m_commit = 0;
    for (int i = 0; i < 5; i++) held[i] = 0;
    evp[0] = 5'b0; evp[1] = 5'b0;
  endtask

  task automatic model_edge();
    logic [4:0] e;
    logic [4:0] nev;
    bit l, r, u, d, s;
    int pre, n;
    e = evp[1];
    l = e[0]; r = e[1]; u = e[2]; d = e[3]; s = e[4];
    m_commit = 0;
    if (m_mode == 2) begin
      m_opt = m_shadow; m_commit = 1; m_mode = 0;
    end else if (s) begin
      if (m_mode == 0) begin m_shadow = m_opt; m_mode = 1; end
      else m_mode = 2;
    end else if (l && r) begin
      if (m_mode == 1) m_mode = 0;
    end else begin
      pre = m_cur;
      if (l) m_cur = (m_cur + 7) % 8;
      if (r) m_cur = (m_cur + 1) % 8;
      if (u != d) begin
        if (m_mode == 0) m_sel = (m_sel + (u ? 1 : 3)) % 4;
        else m_shadow[pre] = u;
      end
    end
    // An event is due at hold index 0, and for L/R at DLY, DLY+PER, DLY+2*PER, ...
    nev = 5'b0;
    for (int i = 0; i < 5; i++) begin
      if (btns[i]) begin
        n = held[i];
        held[i]++;
        nev[i] = (n == 0) || (i < 2 && n >= DLY && ((n - DLY) % PER) == 0);
      end else begin
        held[i] = 0;
      end
    end
    evp[1] = evp[0];
    evp[0] = nev;
  endtask

  initial model_reset();

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    if (chk_en) begin
      chk("options", options, m_opt);
      chk("sel", sel, m_sel);
      chk("cursor", cursor, m_cur);
      chk("editing", editing, (m_mode == 1));
      chk("commit", commit, m_commit);
      if (commit) commits_seen++;
    end
  end

  task automatic press(input logic [4:0] m, input int hold, input int gap);
    @(negedge clk);
    btns = m;
    repeat (hold) @(negedge clk);
    btns = 5'b0;
    repeat (gap) @(negedge clk);
    $display("txn mask=%05b hold=%0d gap=%0d -> options=%02h sel=%0d cursor=%0d editing=%0b",
             m, hold, gap, options, sel, cursor, editing);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_options"}, options, 0);
    chk({tag, "_sel"}, sel, 0);
    chk({tag, "_cursor"}, cursor, 0);
    chk({tag, "_editing"}, editing, 0);
    chk({tag, "_commit"}, commit, 0);
  endtask

  localparam logic [4:0] L = 5'b00001, R = 5'b00010, U = 5'b00100, D = 5'b01000, S = 5'b10000;

  initial begin
    int c0;
    int exp_sel [5];
    exp_sel = '{1, 2, 3, 0, 1};
    #2 rst_n = 1'b0;
    chk_en = 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check_reset_vals("reset");

    // Cursor walk
    repeat (3) press(R, 1, 3);
    chk("cursor_r3", cursor, 3);
    repeat (5) press(L, 1, 3);
    chk("cursor_l5", cursor, 6);
    chk("options_walk", options, 8'h00);
    chk("sel_walk", sel, 0);

    // Select stepping in browse
    for (int i = 0; i < 5; i++) begin
      press(U, 1, 3);
      chk("sel_up", sel, exp_sel[i]);
    end
    repeat (2) press(D, 1, 3);
    chk("sel_down", sel, 3);

    // Full edit from cursor 0
    repeat (2) press(R, 1, 3);
    chk("cursor_home", cursor, 0);
    c0 = commits_seen;
    press(S, 1, 3);
    chk("editing_on", editing, 1);
    press(R, 1, 3); press(R, 1, 3); press(U, 1, 3); press(R, 1, 3); press(U, 1, 3);
    chk("options_held", options, 8'h00);
    chk("editing_mid", editing, 1);
    @(negedge clk);
    btns = S;
    @(posedge clk);
    #1;
    @(negedge clk);
    btns = 5'b0;
    for (int j = 1; j <= 4; j++) begin
      @(posedge clk);
      #1 chk("commit_timing", commit, (j == 3));
    end
    repeat (2) @(negedge clk);
    chk("options_applied", options, 8'h0C);
    chk("commit_once", commits_seen - c0, 1);
    chk("editing_off", editing, 0);

    // Cancel
    c0 = commits_seen;
    press(S, 1, 3);
    press(D, 1, 3);
    press(L | R, 1, 4);
    chk("cancel_options", options, 8'h0C);
    chk("cancel_editing", editing, 0);
    chk("cancel_commit", commits_seen - c0, 0);
    chk("cancel_cursor", cursor, 3);

    // Auto-repeat
    repeat (3) press(L, 1, 3);
    chk("cursor_zero", cursor, 0);
    press(R, 41, 4);
    chk("repeat_cursor", cursor, 6);
    press(U, 100, 4);
    chk("hold_u_sel", sel, 0);

    // Reset in the middle of an edit
    c0 = commits_seen;
    press(S, 1, 3);
    press(R, 1, 3);
    press(U, 1, 3);
    chk("pre_reset_editing", editing, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_vals("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_reset_vals("after_reset");
    chk("reset_no_commit", commits_seen - c0, 0);

    // Randomised traffic against the model
    for (int t = 0; t < 150; t++) begin
      logic [4:0] m;
      int pick;
      pick = $urandom_range(0, 9);
      case (pick)
        0: m = S;
        1: m = L | R;
        2: m = U | D;
        3: m = 5'($urandom_range(0, 31));
        4, 5: m = ($urandom_range(0, 1) != 0) ? L : R;
        6: m = (($urandom_range(0, 1) != 0) ? L : R) | (($urandom_range(0, 1) != 0) ? U : D);
        default: m = ($urandom_range(0, 1) != 0) ? U : D;
      endcase
      press(m, $urandom_range(1, 30), $urandom_range(0, 4));
    end
    repeat (6) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
